// File: rtl/pulse_cnt_arbiter.sv
// -----------------------------------------------------------------------------
// pulse_cnt_arbiter
//   Shares one pulse-counting resource among N_REQ requesters. Requesters are
//   granted round-robin. While a requester is granted, each cycle in which its
//   pulse bit is high advances the count. The grant ends in one of two ways:
//   a one-cycle done strobe when the count reaches TARGET, or a one-cycle
//   abort strobe when the requester withdraws or stays pulse-less for TIMEOUT
//   cycles. The next requester is then considered.
//
//   Ports
//     clk_i    : clock, rising edge
//     rst_ni   : asynchronous active-low reset
//     req_i    : per-requester level request, held until done/abort
//     pulse_i  : per-requester pulse; only the granted bit is used
//     gnt_o    : one-hot grant, high only while in GRANT
//     busy_o   : high in every state except IDLE
//     done_o   : one-cycle completion strobe
//     abort_o  : one-cycle abort strobe (withdrawal or timeout)
//     id_o     : index of the current or last granted requester
//     cnt_o    : pulses counted in the current or last grant
//
//   All outputs are decoded from registered state only, so there is no
//   combinational path from any input to any output.
// -----------------------------------------------------------------------------
module pulse_cnt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TARGET  = 3,
  parameter int TIMEOUT = 16,
  localparam int IDW    = (N_REQ <= 2) ? 1 : $clog2(N_REQ),
  localparam int CW     = $clog2(TARGET + 1),
  localparam int TW     = $clog2(TIMEOUT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] pulse_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             abort_o,
  output logic [IDW-1:0]   id_o,
  output logic [CW-1:0]    cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q,   ptr_d;
  logic [IDW-1:0] id_q,    id_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic           found_s;
  logic [IDW-1:0] pick_s;
  logic [IDW:0]   idx_s;
  logic [IDW-1:0] nxt_id_s;

  // Round-robin pick: first set request searching upward from ptr_q, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = {1'b0, ptr_q} + (IDW+1)'(i);
      if (idx_s >= (IDW+1)'(N_REQ)) begin
        idx_s = idx_s - (IDW+1)'(N_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_i[idx_s[IDW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = idx_s[IDW-1:0];
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Pointer value after a grant finishes: the requester after the one served.
  assign nxt_id_s = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          id_d    = pick_s;
          cnt_d   = '0;
          timer_d = '0;
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // Withdrawal wins over a same-cycle pulse, which is then not counted.
        if (!req_i[id_q]) begin
          state_d = S_ABORT;
        end else if (pulse_i[id_q]) begin
          cnt_d   = cnt_q + CW'(1);
          timer_d = '0;
          if (cnt_q == CW'(TARGET - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GRANT;
          end
        end else begin
          // Timer holds on the final pulse-less cycle so it never passes TIMEOUT-1.
          if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = S_ABORT;
          end else begin
            timer_d = timer_q + TW'(1);
            state_d = S_GRANT;
          end
        end
      end
      S_DONE: begin
        ptr_d   = nxt_id_s;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        ptr_d   = nxt_id_s;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from registered state.
  always_comb begin
    gnt_o   = '0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    abort_o = 1'b0;
    id_o    = id_q;
    cnt_o   = cnt_q;
    case (state_q)
      S_IDLE:  busy_o     = 1'b0;
      S_GRANT: gnt_o[id_q] = 1'b1;
      S_DONE:  done_o     = 1'b1;
      S_ABORT: abort_o    = 1'b1;
      default: busy_o     = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pulse_cnt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pulse_cnt_arbiter
//   Self-checking bench for pulse_cnt_arbiter with default parameters.
//   Each test task drives stimulus and checks outputs inline; expected
//   done/abort events are pushed to a scoreboard queue when stimulus is
//   driven and popped by a monitor when the DUT strobes done_o/abort_o.
// -----------------------------------------------------------------------------
module tb_pulse_cnt_arbiter;

  localparam int N_REQ   = 4;
  localparam int TARGET  = 3;
  localparam int TIMEOUT = 16;
  localparam int IDW     = 2;
  localparam int CW      = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] pulse_i;
  logic [N_REQ-1:0] gnt_o;
  logic             busy_o;
  logic             done_o;
  logic             abort_o;
  logic [IDW-1:0]   id_o;
  logic [CW-1:0]    cnt_o;

  typedef struct {
    logic           is_done;
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pulse_cnt_arbiter #(
    .N_REQ  (N_REQ),
    .TARGET (TARGET),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .pulse_i(pulse_i),
    .gnt_o  (gnt_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .abort_o(abort_o),
    .id_o   (id_o),
    .cnt_o  (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor plus per-cycle invariants, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      n_checks++;
      if ((done_o && abort_o) || ($countones(gnt_o) > 1)) begin
        n_fail++;
        $display("FAIL invariant: done=%0b abort=%0b gnt=%b (need exclusive strobes, one-hot grant)",
                 done_o, abort_o, gnt_o);
      end
      if (done_o || abort_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: done=%0b abort=%0b id=%0d cnt=%0d with no event expected",
                   done_o, abort_o, id_o, cnt_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({done_o, abort_o, id_o, cnt_o} !== {e.is_done, ~e.is_done, e.id, e.cnt}) begin
            n_fail++;
            $display("FAIL sb_event: got done=%0b abort=%0b id=%0d cnt=%0d, need done=%0b id=%0d cnt=%0d",
                     done_o, abort_o, id_o, cnt_o, e.is_done, e.id, e.cnt);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic is_done, input int id, input int cnt);
    exp_t e;
    e.is_done = is_done;
    e.id      = IDW'(id);
    e.cnt     = CW'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    req_i   = '0;
    pulse_i = '0;
    tick();
    tick();
    rst_ni  = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    req_i   = '0;
    pulse_i = '0;
    #1;
    n_checks++;
    if ({gnt_o, busy_o, done_o, abort_o, id_o, cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b busy=%0b done=%0b abort=%0b id=%0d cnt=%0d, need all 0",
               gnt_o, busy_o, done_o, abort_o, id_o, cnt_o);
    end
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_done();
    do_reset();
    req_i   = 4'b0001;
    pulse_i = 4'b0001;
    push_exp(1'b1, 0, TARGET);
    for (int k = 0; k < TARGET; k++) begin
      tick();
      n_checks++;
      if (gnt_o !== 4'b0001 || cnt_o !== CW'(k) || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL single_grant[%0d]: gnt=%b cnt=%0d busy=%0b, need gnt=0001 cnt=%0d busy=1",
                 k, gnt_o, cnt_o, busy_o, k);
      end
    end
    tick();
    req_i   = '0;
    pulse_i = '0;
    n_checks++;
    if (done_o !== 1'b1 || gnt_o !== 4'b0000 || id_o !== 2'd0 || cnt_o !== CW'(TARGET)) begin
      n_fail++;
      $display("FAIL single_done: done=%0b gnt=%b id=%0d cnt=%0d, need done=1 gnt=0000 id=0 cnt=%0d",
               done_o, gnt_o, id_o, cnt_o, TARGET);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%0b done=%0b, need 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_round_robin();
    int            order[5] = '{0, 1, 2, 3, 0};
    int            grants    = 0;
    int            dones     = 0;
    int            last_done = -1;
    logic [N_REQ-1:0] prev_gnt = '0;
    do_reset();
    for (int k = 0; k < 5; k++) push_exp(1'b1, order[k], TARGET);
    req_i   = 4'b1111;
    pulse_i = 4'b1111;
    for (int cyc = 1; cyc <= 80 && dones < 5; cyc++) begin
      tick();
      if (gnt_o !== 4'b0000 && prev_gnt === 4'b0000) begin
        n_checks++;
        if (grants >= 5 || gnt_o !== (4'b0001 << order[grants])) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: gnt=%b, need requester %0d",
                   grants, gnt_o, (grants < 5) ? order[grants] : -1);
        end
        grants++;
      end
      if (done_o === 1'b1) begin
        // One grant of TARGET cycles plus the DONE and IDLE cycles.
        if (last_done >= 0) begin
          n_checks++;
          if (cyc - last_done != TARGET + 2) begin
            n_fail++;
            $display("FAIL rr_gap: done strobes %0d cycles apart, need %0d",
                     cyc - last_done, TARGET + 2);
          end
        end
        last_done = cyc;
        dones++;
        if (dones == 5) begin
          req_i   = '0;
          pulse_i = '0;
        end
      end
      prev_gnt = gnt_o;
    end
    n_checks++;
    if (dones != 5 || grants != 5) begin
      n_fail++;
      $display("FAIL rr_count: dones=%0d grants=%0d, need 5 5", dones, grants);
    end
    tick();
  endtask

  task automatic test_timeout();
    int   gcnt = 0;
    logic seen = 1'b0;
    do_reset();
    req_i   = 4'b0010;
    pulse_i = 4'b0000;
    push_exp(1'b0, 1, 0);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (abort_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (gnt_o === 4'b0010) gcnt++;
    end
    n_checks++;
    if (!seen || gcnt != TIMEOUT || id_o !== 2'd1 || cnt_o !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout: abort_seen=%0b grant_cycles=%0d id=%0d cnt=%0d, need 1 %0d 1 0",
               seen, gcnt, id_o, cnt_o, TIMEOUT);
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_ignore_others();
    do_reset();
    req_i   = 4'b0001;
    pulse_i = 4'b0001;
    tick();
    tick();
    pulse_i = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (cnt_o !== 2'd1 || done_o !== 1'b0 || gnt_o !== 4'b0001) begin
        n_fail++;
        $display("FAIL ignore_others[%0d]: cnt=%0d done=%0b gnt=%b, need cnt=1 done=0 gnt=0001",
                 k, cnt_o, done_o, gnt_o);
      end
    end
    push_exp(1'b0, 0, 1);
    req_i   = '0;
    pulse_i = '0;
    tick();
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    req_i   = 4'b0001;
    pulse_i = 4'b0001;
    tick();
    tick();
    tick();
    n_checks++;
    if (cnt_o !== 2'd2) begin
      n_fail++;
      $display("FAIL withdraw_pre: cnt=%0d, need 2", cnt_o);
    end
    push_exp(1'b0, 0, 2);
    req_i = 4'b0000;
    tick();
    n_checks++;
    if (abort_o !== 1'b1 || done_o !== 1'b0 || cnt_o !== 2'd2 || id_o !== 2'd0 || gnt_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL withdraw: abort=%0b done=%0b cnt=%0d id=%0d gnt=%b, need 1 0 2 0 0000",
               abort_o, done_o, cnt_o, id_o, gnt_o);
    end
    pulse_i = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i   = 4'b0100;
    pulse_i = 4'b0100;
    tick();
    tick();
    tick();
    n_checks++;
    if (gnt_o !== 4'b0100 || cnt_o !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_mid_pre: gnt=%b cnt=%0d, need 0100 2", gnt_o, cnt_o);
    end
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({gnt_o, busy_o, done_o, abort_o, id_o, cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: gnt=%b busy=%0b done=%0b abort=%0b id=%0d cnt=%0d, need all 0",
               gnt_o, busy_o, done_o, abort_o, id_o, cnt_o);
    end
    tick();
    rst_ni  = 1'b1;
    req_i   = 4'b0101;
    pulse_i = 4'b0000;
    tick();
    n_checks++;
    if (gnt_o !== 4'b0001 || id_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: gnt=%b id=%0d, need 0001 0", gnt_o, id_o);
    end
    push_exp(1'b0, 0, 0);
    req_i = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_done();
    test_round_robin();
    test_timeout();
    test_ignore_others();
    test_withdraw();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected events never seen, need 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
